// File: rtl/mining_dispatcher.sv
// mining_dispatcher: sweeps a nonce job across NUM_CORES mining cores, tracks
// per-core busy timers, attributes matches to held nonces and reports one
// hit/miss result per job to the host.

// Per-core slot: issue strobe, busy timer and held nonce/opcode registers.
module mining_core_slot #(
    parameter int         CORE_LATENCY = 64,
    parameter logic [7:0] MINE_OPCODE  = 8'h51,
    parameter int         TW           = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_issue,
    input  logic [80:0] i_nonce,
    output logic        o_busy,
    output logic        o_valid,
    output logic [7:0]  o_opcode,
    output logic [80:0] o_nonce
);
    localparam logic [TW-1:0] LAT = TW'(CORE_LATENCY);

    logic [TW-1:0] r_timer;
    logic          r_valid;
    logic [7:0]    r_opcode;
    logic [80:0]   r_nonce;

    // Issue loads timer and nonce; otherwise the timer counts down to idle.
    // Operand/opcode hold their last value between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer  <= '0;
            r_valid  <= 1'b0;
            r_opcode <= '0;
            r_nonce  <= '0;
        end else begin
            r_valid <= i_issue;
            if (i_issue) begin
                r_timer  <= LAT;
                r_nonce  <= i_nonce;
                r_opcode <= MINE_OPCODE;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - 1'b1;
            end
        end
    end

    assign o_busy   = (r_timer != '0);
    assign o_valid  = r_valid;
    assign o_opcode = r_opcode;
    assign o_nonce  = r_nonce;
endmodule

module mining_dispatcher #(
    parameter int         NUM_CORES    = 2,
    parameter int         CORE_LATENCY = 64,
    parameter logic [7:0] MINE_OPCODE  = 8'h51
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [80:0]             job_base_nonce,
    input  logic [31:0]             job_count,
    output logic [8*NUM_CORES-1:0]  core_opcode,
    output logic [81*NUM_CORES-1:0] core_operand,
    output logic [NUM_CORES-1:0]    core_valid,
    input  logic [NUM_CORES-1:0]    core_match,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    result_hit,
    output logic [80:0]             result_nonce,
    output logic [3:0]              result_core,
    output logic [31:0]             nonces_issued
);
    localparam int RW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int TW = $clog2(CORE_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DISPATCH, S_DRAIN, S_FLUSH, S_REPORT
    } state_t;

    state_t                        r_state, w_next_state;
    logic [80:0]                   r_next_nonce;
    logic [31:0]                   r_remaining;
    logic [31:0]                   r_issued;
    logic [RW-1:0]                 r_rr;
    logic                          r_hit;
    logic [80:0]                   r_res_nonce;
    logic [3:0]                    r_res_core;

    logic [NUM_CORES-1:0]          w_busy;
    logic [NUM_CORES-1:0][80:0]    w_held;
    logic [NUM_CORES-1:0][7:0]     w_opcode;
    logic [NUM_CORES-1:0]          w_issue_vec;
    logic [NUM_CORES-1:0]          w_match_vec;
    logic                          w_match_any;
    logic [RW-1:0]                 w_match_sel;
    logic                          w_idle_found;
    logic [RW-1:0]                 w_idle_sel;
    logic                          w_issue;
    logic                          w_hit;
    logic                          w_all_idle;

    // (a + k) mod NUM_CORES, with a < NUM_CORES and k <= NUM_CORES
    function automatic logic [RW-1:0] rr_add(input logic [RW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return RW'(s);
    endfunction

    genvar g;
    generate
        for (g = 0; g < NUM_CORES; g++) begin : g_core
            mining_core_slot #(
                .CORE_LATENCY (CORE_LATENCY),
                .MINE_OPCODE  (MINE_OPCODE),
                .TW           (TW)
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .i_issue  (w_issue_vec[g]),
                .i_nonce  (r_next_nonce),
                .o_busy   (w_busy[g]),
                .o_valid  (core_valid[g]),
                .o_opcode (w_opcode[g]),
                .o_nonce  (w_held[g])
            );
        end
    endgenerate

    assign core_opcode  = w_opcode;
    assign core_operand = w_held;

    // A match only counts on a core that is busy this cycle.
    assign w_match_vec = core_match & w_busy;
    assign w_match_any = |w_match_vec;
    assign w_all_idle  = ~|w_busy;
    assign w_hit       = ((r_state == S_DISPATCH) || (r_state == S_DRAIN)) && w_match_any;
    assign w_issue     = (r_state == S_DISPATCH) && (r_remaining != 32'd0) &&
                         !w_match_any && w_idle_found;

    // Lowest-index busy core that reports a match wins.
    always_comb begin
        w_match_sel = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_match_vec[i]) w_match_sel = RW'(i);
        end
    end

    // Round-robin: first idle core at or after the rr pointer, wrapping.
    always_comb begin
        w_idle_found = 1'b0;
        w_idle_sel   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!w_idle_found && !w_busy[rr_add(r_rr, k)]) begin
                w_idle_found = 1'b1;
                w_idle_sel   = rr_add(r_rr, k);
            end
        end
    end

    // One-hot issue strobe towards the selected core.
    always_comb begin
        w_issue_vec = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_issue_vec[i] = w_issue && (w_idle_sel == RW'(i));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        job_ready    = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) w_next_state = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (w_match_any)
                    w_next_state = S_FLUSH;
                else if ((r_remaining == 32'd0) || (w_issue && (r_remaining == 32'd1)))
                    w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_match_any)     w_next_state = S_FLUSH;
                else if (w_all_idle) w_next_state = S_REPORT;
            end
            S_FLUSH: begin
                if (w_all_idle) w_next_state = S_REPORT;
            end
            S_REPORT: begin
                result_valid = 1'b1;
                if (result_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Job latch, sweep counters, rr pointer and result capture. Result fields
    // are cleared at job accept so a miss reports zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_next_nonce <= '0;
            r_remaining  <= '0;
            r_issued     <= '0;
            r_rr         <= '0;
            r_hit        <= 1'b0;
            r_res_nonce  <= '0;
            r_res_core   <= '0;
        end else begin
            if ((r_state == S_IDLE) && job_valid) begin
                r_next_nonce <= job_base_nonce;
                r_remaining  <= job_count;
                r_issued     <= '0;
                r_hit        <= 1'b0;
                r_res_nonce  <= '0;
                r_res_core   <= '0;
            end
            if (w_issue) begin
                r_next_nonce <= r_next_nonce + 81'd1;
                r_remaining  <= r_remaining - 32'd1;
                r_issued     <= r_issued + 32'd1;
                r_rr         <= rr_add(w_idle_sel, 1);
            end
            if (w_hit) begin
                r_hit       <= 1'b1;
                r_res_nonce <= w_held[w_match_sel];
                r_res_core  <= 4'(w_match_sel);
            end
        end
    end

    assign result_hit    = r_hit;
    assign result_nonce  = r_res_nonce;
    assign result_core   = r_res_core;
    assign nonces_issued = r_issued;
endmodule

// File: tb/tb_mining_dispatcher.sv
// Testbench for mining_dispatcher: directed scenarios plus randomized jobs,
// checked against a cycle-indexed reference model of issue/match/report rules.
module tb_mining_dispatcher;
    localparam int NC  = 2;
    localparam int LAT = 4;

    logic              clk, rst;
    logic              job_valid, job_ready;
    logic [80:0]       job_base_nonce;
    logic [31:0]       job_count;
    logic [8*NC-1:0]   core_opcode;
    logic [81*NC-1:0]  core_operand;
    logic [NC-1:0]     core_valid, core_match;
    logic              result_valid, result_ready, result_hit;
    logic [80:0]       result_nonce;
    logic [3:0]        result_core;
    logic [31:0]       nonces_issued;

    int total = 0;
    int bad   = 0;

    mining_dispatcher #(.NUM_CORES(NC), .CORE_LATENCY(LAT), .MINE_OPCODE(8'h51)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_base_nonce(job_base_nonce), .job_count(job_count),
        .core_opcode(core_opcode), .core_operand(core_operand),
        .core_valid(core_valid), .core_match(core_match),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_hit(result_hit), .result_nonce(result_nonce),
        .result_core(result_core), .nonces_issued(nonces_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state. Cycle x=0 is the first cycle after the job is accepted.
    int          m_rr;
    int          mm_core[2];
    int          mm_cyc[2];
    int          e_core[$];
    int          e_cyc[$];
    logic [80:0] e_nonce[$];
    bit          e_hit;
    logic [80:0] e_rnonce;
    int          e_rcore;
    int          e_R;

    function automatic bit matched(input int c, input int x);
        return (mm_cyc[0] == x && mm_core[0] == c) || (mm_cyc[1] == x && mm_core[1] == c);
    endfunction

    // A nonce chosen in cycle x shows core_valid in x+1 and keeps the core busy
    // for cycles x+1..x+LAT. Report appears two cycles after the last busy cycle.
    task automatic model_job(input logic [80:0] base, input int count);
        int          bfrom[NC];
        int          buntil[NC];
        logic [80:0] held[NC];
        logic [80:0] nx;
        int          rem, x, maxbu, c;
        bit          stop, found;
        for (int i = 0; i < NC; i++) begin
            bfrom[i] = -10; buntil[i] = -10; held[i] = '0;
        end
        e_core.delete(); e_cyc.delete(); e_nonce.delete();
        e_hit = 0; e_rnonce = '0; e_rcore = 0;
        nx = base; rem = count; maxbu = -1; stop = 0; x = 0;
        while (!stop && (rem > 0 || x <= maxbu)) begin
            for (int i = 0; i < NC; i++) begin
                if (!stop && matched(i, x) && bfrom[i] <= x && x <= buntil[i]) begin
                    stop = 1; e_hit = 1; e_rnonce = held[i]; e_rcore = i;
                end
            end
            if (!stop && rem > 0) begin
                found = 0;
                for (int k = 0; k < NC; k++) begin
                    c = (m_rr + k) % NC;
                    if (!found && x > buntil[c]) begin
                        found = 1;
                        bfrom[c] = x + 1; buntil[c] = x + LAT; held[c] = nx;
                        e_core.push_back(c); e_nonce.push_back(nx); e_cyc.push_back(x + 1);
                        nx = nx + 81'd1; rem--; m_rr = (c + 1) % NC;
                        if (buntil[c] > maxbu) maxbu = buntil[c];
                    end
                end
            end
            x++;
        end
        e_R = (maxbu + 2 > 2) ? maxbu + 2 : 2;
    endtask

    task automatic clear_matches();
        mm_core[0] = 0; mm_cyc[0] = -1;
        mm_core[1] = 0; mm_cyc[1] = -1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        job_valid = 1'b0; result_ready = 1'b0; core_match = '0;
        job_base_nonce = '0; job_count = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_rr = 0;
        clear_matches();
    endtask

    task automatic run_job(input logic [80:0] base, input logic [31:0] cnt,
                           input int rdly, input string name);
        int          o_core[$];
        int          o_cyc[$];
        logic [80:0] o_nonce[$];
        int          x, rx, n;
        bit          got;
        logic        h_hit;
        logic [80:0] h_nonce;
        logic [3:0]  h_core;
        model_job(base, int'(cnt));
        @(negedge clk);
        total++;
        if (job_ready !== 1'b1) begin
            bad++; $display("FAIL %s job_ready: got %b want 1", name, job_ready);
        end
        job_valid = 1'b1; job_base_nonce = base; job_count = cnt;
        @(posedge clk);
        x = 0; got = 0; rx = -1;
        while (!got && x < 300) begin
            @(negedge clk);
            job_valid = 1'b0;
            for (int c = 0; c < NC; c++) core_match[c] = matched(c, x);
            for (int c = 0; c < NC; c++) begin
                if (core_valid[c] === 1'b1) begin
                    o_core.push_back(c);
                    o_nonce.push_back(core_operand[81*c +: 81]);
                    o_cyc.push_back(x);
                    total++;
                    if (core_opcode[8*c +: 8] !== 8'h51) begin
                        bad++; $display("FAIL %s opcode core%0d: got %h want 51", name, c, core_opcode[8*c +: 8]);
                    end
                end
            end
            if (result_valid === 1'b1) begin
                got = 1; rx = x;
            end else begin
                @(posedge clk);
                x++;
            end
        end
        core_match = '0;
        total++;
        if (!got) begin
            bad++; $display("FAIL %s result_timeout: no result_valid in 300 cycles, want at cycle %0d", name, e_R);
            return;
        end
        if (rx != e_R) begin
            bad++; $display("FAIL %s result_latency: got cycle %0d want %0d", name, rx, e_R);
        end
        total++;
        if (o_core.size() != e_core.size()) begin
            bad++; $display("FAIL %s issue_count: got %0d want %0d", name, o_core.size(), e_core.size());
        end
        n = (o_core.size() < e_core.size()) ? o_core.size() : e_core.size();
        for (int i = 0; i < n; i++) begin
            total++;
            if (o_core[i] != e_core[i] || o_nonce[i] !== e_nonce[i] || o_cyc[i] != e_cyc[i]) begin
                bad++;
                $display("FAIL %s issue%0d: got core%0d nonce %h cyc %0d want core%0d nonce %h cyc %0d",
                         name, i, o_core[i], o_nonce[i], o_cyc[i], e_core[i], e_nonce[i], e_cyc[i]);
            end
        end
        total++;
        if (result_hit !== e_hit || result_nonce !== e_rnonce || result_core !== 4'(e_rcore)) begin
            bad++;
            $display("FAIL %s result: got hit=%b nonce=%h core=%0d want hit=%b nonce=%h core=%0d",
                     name, result_hit, result_nonce, result_core, e_hit, e_rnonce, e_rcore);
        end
        total++;
        if (nonces_issued !== 32'(e_core.size())) begin
            bad++; $display("FAIL %s nonces_issued: got %0d want %0d", name, nonces_issued, e_core.size());
        end
        h_hit = result_hit; h_nonce = result_nonce; h_core = result_core;
        repeat (rdly) begin
            @(posedge clk); @(negedge clk);
            total++;
            if (result_valid !== 1'b1 || result_hit !== h_hit || result_nonce !== h_nonce || result_core !== h_core) begin
                bad++; $display("FAIL %s result_hold: got valid=%b hit=%b want held valid=1 hit=%b", name, result_valid, result_hit, h_hit);
            end
        end
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        total++;
        if (result_valid !== 1'b0 || job_ready !== 1'b1) begin
            bad++; $display("FAIL %s handshake: got valid=%b ready=%b want 0 1", name, result_valid, job_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        job_valid = 1'b0; result_ready = 1'b0; core_match = '0;
        job_base_nonce = '0; job_count = '0;
        #12;
        total++;
        if (job_ready !== 1'b1 || core_valid !== '0 || result_valid !== 1'b0 || nonces_issued !== '0 ||
            core_operand !== '0 || core_opcode !== '0 || result_hit !== 1'b0 || result_nonce !== '0 ||
            result_core !== '0) begin
            bad++;
            $display("FAIL reset_state: got ready=%b cv=%b rv=%b issued=%0d hit=%b want 1 0 0 0 0",
                     job_ready, core_valid, result_valid, nonces_issued, result_hit);
        end
        apply_reset();
    endtask

    task automatic test_miss_sweep();
        apply_reset();
        run_job(81'd100, 32'd3, 1, "miss_sweep");
    endtask

    task automatic test_hit_core1();
        apply_reset();
        mm_core[0] = 1; mm_cyc[0] = 3;
        run_job(81'd100, 32'd3, 0, "hit_core1");
    endtask

    task automatic test_simul_match();
        apply_reset();
        mm_core[0] = 0; mm_cyc[0] = 2;
        mm_core[1] = 1; mm_cyc[1] = 2;
        run_job(81'd100, 32'd3, 0, "simul_match");
    endtask

    task automatic test_timer_edge();
        apply_reset();
        mm_core[0] = 0; mm_cyc[0] = LAT;
        run_job(81'd100, 32'd3, 0, "timer_edge");
    endtask

    task automatic test_idle_match();
        apply_reset();
        mm_core[0] = 0; mm_cyc[0] = 0;
        mm_core[1] = 0; mm_cyc[1] = LAT + 1;
        run_job(81'd55, 32'd1, 0, "idle_match");
    endtask

    task automatic test_nonce_wrap();
        logic [80:0] ones;
        apply_reset();
        ones = '1;
        run_job(ones, 32'd2, 0, "nonce_wrap");
    endtask

    task automatic test_zero_count();
        apply_reset();
        run_job(81'd7, 32'd0, 0, "zero_count");
    endtask

    task automatic test_back_to_back();
        logic [95:0] r96;
        apply_reset();
        for (int j = 0; j < 10; j++) begin
            r96 = {$urandom, $urandom, $urandom};
            for (int k = 0; k < 2; k++) begin
                mm_core[k] = $urandom_range(0, NC - 1);
                mm_cyc[k]  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 14));
            end
            run_job(r96[80:0], 32'($urandom_range(0, 6)), int'($urandom_range(0, 2)), "back_to_back");
        end
        clear_matches();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        job_valid = 1'b1; job_base_nonce = 81'd900; job_count = 32'd5;
        @(posedge clk);
        @(negedge clk);
        job_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (core_valid !== 2'b01) begin
            bad++; $display("FAIL reset_mid_pre: got cv=%b want 01", core_valid);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (core_valid !== '0 || job_ready !== 1'b1 || result_valid !== 1'b0 || nonces_issued !== '0 || core_operand !== '0) begin
            bad++; $display("FAIL reset_mid_async: got cv=%b ready=%b rv=%b issued=%0d want 0 1 0 0",
                            core_valid, job_ready, result_valid, nonces_issued);
        end
        @(negedge clk);
        rst = 1'b0;
        m_rr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if (result_valid !== 1'b0 || core_valid !== '0) begin
                bad++; $display("FAIL reset_mid_quiet: got rv=%b cv=%b want 0 0", result_valid, core_valid);
            end
        end
        run_job(81'd900, 32'd2, 0, "reset_mid_recover");
    endtask

    initial begin
        m_rr = 0;
        clear_matches();
        test_reset();
        test_miss_sweep();
        test_hit_core1();
        test_simul_match();
        test_timer_edge();
        test_idle_match();
        test_nonce_wrap();
        test_zero_count();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mining_dispatcher.md
Name: mining_dispatcher

Overview:
Work source and result sink for the multi-core T81 mining pipeline. Accepts a job (base nonce plus nonce count) and sweeps it across NUM_CORES pipeline cores by driving each core's opcode/operand/valid. It times every in-flight nonce, attributes each core's match_found to the nonce that core holds, and reports a single hit/miss result per job to the host controller.

Parameters:
NUM_CORES, 2, number of mining cores driven (1..16)
CORE_LATENCY, 64, cycles a core is considered busy after issue (pipeline depth incl. SHA3); must be >=2
MINE_OPCODE, 8'h51, opcode driven with every issued nonce

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
job_valid  input  1  job offered
job_ready  output  1  dispatcher can accept a job
job_base_nonce  input  81  first nonce of job
job_count  input  32  number of nonces in job (0 allowed)
core_opcode  output  8*NUM_CORES  per-core opcode, core i at [8i+7:8i]
core_operand  output  81*NUM_CORES  per-core operand (nonce), core i at [81i+80:81i]
core_valid  output  NUM_CORES  one-cycle issue strobe per core
core_match  input  NUM_CORES  per-core match_found from pipeline
result_valid  output  1  result held until accepted
result_ready  input  1  host accepts result
result_hit  output  1  1 = match found, 0 = job exhausted
result_nonce  output  81  matching nonce (0 on miss)
result_core  output  4  core index of match (0 on miss)
nonces_issued  output  32  nonces issued for current/last job

Behaviour:
- Reset (async, rst=1): state IDLE; job_ready=1; all core_* outputs, result_*, nonces_issued, core timers, rr pointer = 0.
- States: IDLE, DISPATCH, DRAIN, FLUSH, REPORT.
- IDLE: job_ready=1. On job_valid: latch next_nonce=job_base_nonce, remaining=job_count, nonces_issued=0, go DISPATCH. job_ready=0 in all other states.
- Core busy = timer!=0. Issue loads timer=CORE_LATENCY and stores the nonce in per-core held_nonce; timer decrements by 1 each cycle while nonzero.
- DISPATCH: at most one issue per cycle, only while remaining!=0. Target = first idle core at or after rr pointer (round-robin, wrap). That cycle: core_valid[i]=1, core_operand[i]=next_nonce, core_opcode[i]=MINE_OPCODE. Then next_nonce+=1 mod 2^81 (wrap 1FF..F -> 0), remaining-=1, nonces_issued+=1, rr=i+1 mod NUM_CORES. core_valid is registered; opcode/operand hold their last value between strobes. remaining reaching 0 -> DRAIN.
- Match attribution: core_match[i] counts only if core i is busy in that cycle (timer!=0 before decrement, so timer==1 expiring with match counts). Match on an idle core is ignored, including the cycle a nonce is issued to it. If multiple cores match in one cycle, lowest index wins.
- Valid match in DISPATCH or DRAIN: capture result_hit=1, result_nonce=held_nonce[i], result_core=i; stop issuing; go FLUSH.
- DRAIN: no issue; wait for matches; when all timers==0 with no match -> REPORT with result_hit=0, nonce/core=0.
- FLUSH: no issue, matches ignored; when all timers==0 -> REPORT.
- REPORT: result_valid=1, fields stable; on result_ready -> IDLE (result_valid=0 next cycle).
- job_count=0: DISPATCH -> DRAIN next cycle -> REPORT miss; nonces_issued=0.
- Reset mid-job: everything returns to reset values immediately, in-flight work abandoned, no result reported.

Test Plan:
- NUM_CORES=2, CORE_LATENCY=4; job base=100, count=3, no matches -> core_valid[0] @100, core_valid[1] @101, core_valid[0] @102 once core0 idle (4 cycles after first issue); result_hit=0, nonces_issued=3.
- Same job, core_match[1] one cycle after nonce 101 issued -> result_hit=1, result_nonce=101, result_core=1; no nonce 102 issued; result_valid only after all timers 0.
- core_match[0] and core_match[1] same cycle, both busy -> result_core=0.
- core_match[0] on the cycle core0's timer==1 -> counted as hit; core_match[0] while core0 idle -> ignored, miss reported.
- Base 0x1FFFFFFFFFFFFFFFFFFFF (all ones), count=2 -> operands all-ones then 0.
- job_count=0 -> miss result within 3 cycles; rst asserted in DISPATCH -> core_valid=0, job_ready=1 asynchronously, no result_valid.
